// File: rtl/data_in_pkg.sv
// Shared constants and types for the 64-to-8 serialiser.
// Default widths, derived chunk count, chunk index width and the session state enum.
// No logic lives here; the top re-derives its own sizes from its parameters.
package data_in_pkg;

  // Default word and chunk widths; the word must be an integer multiple of the chunk.
  localparam int IN_W_DEF  = 64;
  localparam int OUT_W_DEF = 8;

  // Chunks per word and an index wide enough to hold the value NUM_CHUNKS_DEF itself,
  // because "word exhausted" is encoded as idx == NUM_CHUNKS.
  localparam int NUM_CHUNKS_DEF = IN_W_DEF / OUT_W_DEF;
  localparam int IDX_W_DEF      = $clog2(NUM_CHUNKS_DEF) + 1;

  // IDLE ignores chunk requests; RUN streams the latched word.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : data_in_pkg

// File: rtl/data_in_64_to_8_rise_edge_detect.sv
// Rising-edge detector for a level input.
// Latency: pulse is combinational in the cycle the level is first sampled high.
// Backpressure: none; one pulse per low-to-high transition regardless of high time.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  // History flop resets low, so a level already high out of reset counts as a rise.
  logic level_d;

  // Remember last cycle's level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  // High only in the first cycle the level is seen high.
  always_comb begin
    pulse = level & ~level_d;
  end

endmodule : rise_edge_detect

// File: rtl/data_in_64_to_8.sv
// Serialises a latched IN_W-bit word into OUT_W-bit chunks for a byte-wide UART transmitter.
// Latency: data_8/tx_enable update on the edge where manual_start/data_in_enable first rise.
// Backpressure: the transmitter paces us; each data_in_enable rise releases exactly one chunk.
// Optional build macro DATA_IN_LSB_FIRST_EN: chunks leave LSB-first instead of MSB-first.
module data_in_64_to_8
  import data_in_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  data_64,
  input  logic             data_in_enable,
  input  logic             manual_start,
  output logic [OUT_W-1:0] data_8,
  output logic             tx_enable
);

  // Sizes derived from the parameters so a non-default width stays self-consistent.
  localparam int NUM_CHUNKS = IN_W / OUT_W;
  localparam int IDX_W      = $clog2(NUM_CHUNKS) + 1;
  localparam int SEL_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHUNKS);

  // Session state and datapath registers.
  state_t            state;
  state_t            state_nxt;
  logic [IN_W-1:0]   word;
  logic [IN_W-1:0]   word_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [OUT_W-1:0]  data_8_nxt;
  logic              tx_enable_nxt;

  // Edge-detected requests.
  logic              start_rise;
  logic              next_rise;
  logic              running;

  // Chunk views of the latched word, already in transmit order.
  logic [OUT_W-1:0]  word_chunk [NUM_CHUNKS];
  // First chunk taken straight from data_64 on a load.
  logic [OUT_W-1:0]  load_chunk;

  // Start request edge.
  rise_edge_detect u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (manual_start),
    .pulse (start_rise)
  );

  // Next-chunk request edge; the transmitter may hold it high for several cycles.
  rise_edge_detect u_next_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (data_in_enable),
    .pulse (next_rise)
  );

  // Reorder the latched word so that word_chunk[k] is the k-th chunk sent.
  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
`ifdef DATA_IN_LSB_FIRST_EN
    assign word_chunk[g] = word[g*OUT_W +: OUT_W];
`else
    assign word_chunk[g] = word[IN_W-1-g*OUT_W -: OUT_W];
`endif
  end

  // Chunk 0 of a freshly loaded word comes from the input, not the old latched word.
`ifdef DATA_IN_LSB_FIRST_EN
  assign load_chunk = data_64[OUT_W-1:0];
`else
  assign load_chunk = data_64[IN_W-1 -: OUT_W];
`endif

  assign running = (state == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a start enters RUN from anywhere; only reset returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (start_rise) begin
      state_nxt = RUN;
    end
  end

  // Output/datapath next values. A start beats a coincident chunk request, and the
  // request is consumed by the start rather than also advancing the index.
  always_comb begin
    word_nxt      = word;
    idx_nxt       = idx;
    data_8_nxt    = data_8;
    tx_enable_nxt = 1'b0;
    if (start_rise || (next_rise && running && (idx >= IDX_LAST))) begin
      // Session start or word exhausted: latch a fresh word and send its first chunk.
      word_nxt      = data_64;
      idx_nxt       = IDX_ONE;
      data_8_nxt    = load_chunk;
      tx_enable_nxt = 1'b1;
    end else if (next_rise && running) begin
      // Mid-word: send chunk idx of the latched word.
      data_8_nxt    = word_chunk[idx[SEL_W-1:0]];
      idx_nxt       = idx + IDX_ONE;
      tx_enable_nxt = 1'b1;
    end
  end

  // Datapath registers; data_8 holds between events, tx_enable is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word      <= '0;
      idx       <= '0;
      data_8    <= '0;
      tx_enable <= 1'b0;
    end else begin
      word      <= word_nxt;
      idx       <= idx_nxt;
      data_8    <= data_8_nxt;
      tx_enable <= tx_enable_nxt;
    end
  end

endmodule : data_in_64_to_8

// File: tb/tb_data_in_64_to_8.sv
// Directed bench for data_in_64_to_8 (default MSB-first build).
// Expected bytes are hand-derived from the stimulus words.
module tb_data_in_64_to_8;

  localparam int GAP = 30;  // idle cycles between requests (stands in for a UART byte time)

  logic        clk;
  logic        rst_n;
  logic [63:0] data_64;
  logic        data_in_enable;
  logic        manual_start;
  logic [7:0]  data_8;
  logic        tx_enable;

  int n_cmp = 0;
  int n_err = 0;
  int tx_cnt = 0;
  int chg_cnt = 0;
  logic [7:0] d8_prev = 8'h00;
  logic [7:0] last_exp = 8'h00;

  data_in_64_to_8 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_64        (data_64),
    .data_in_enable (data_in_enable),
    .manual_start   (manual_start),
    .data_8         (data_8),
    .tx_enable      (tx_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles and data_8 changes on the falling edge.
  always @(negedge clk) begin
    if (tx_enable === 1'b1) tx_cnt++;
    if (data_8 !== d8_prev) chg_cnt++;
    d8_prev = data_8;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise the selected requests for two cycles, wait out the gap, then check that exactly
  // one strobe fired, data_8 carries the expected byte and it changed at most once.
  task automatic send(input string tag, input bit st, input bit nx, input logic [7:0] exp);
    int t0;
    int c0;
    t0 = tx_cnt;
    c0 = chg_cnt;
    @(posedge clk); #1;
    manual_start   = st;
    data_in_enable = nx;
    repeat (2) @(posedge clk);
    #1;
    manual_start   = 1'b0;
    data_in_enable = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    chk({tag, "_tx"},   64'(tx_cnt - t0), 64'd1);
    chk({tag, "_d8"},   64'(data_8), 64'(exp));
    chk({tag, "_hold"}, 64'(chg_cnt - c0), 64'(exp != last_exp));
    last_exp = exp;
  endtask

  // A chunk request that must be ignored (IDLE): no strobe, data_8 unchanged.
  task automatic idle_pulse(input string tag, input logic [7:0] exp);
    int t0;
    t0 = tx_cnt;
    @(posedge clk); #1;
    data_in_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    data_in_enable = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    chk({tag, "_tx"}, 64'(tx_cnt - t0), 64'd0);
    chk({tag, "_d8"}, 64'(data_8), 64'(exp));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk({tag, "_d8"}, 64'(data_8), 64'h0);
    chk({tag, "_tx"}, 64'(tx_enable), 64'h0);
    last_exp = 8'h00;
  endtask

  logic [7:0] word_a [8];
  logic [7:0] word_b [8];

  initial begin
    rst_n          = 1'b0;
    data_64        = 64'h0;
    data_in_enable = 1'b0;
    manual_start   = 1'b0;
    word_a = '{8'hbb, 8'h94, 8'h1c, 8'h2b, 8'h7e, 8'h1d, 8'h73, 8'h1b};
    word_b = '{8'hbc, 8'ha1, 8'h6b, 8'h88, 8'h8f, 8'h3c, 8'haf, 8'hb4};

    // Reset and IDLE behaviour.
    do_reset("rst");
    idle_pulse("idle0", 8'h00);
    idle_pulse("idle1", 8'h00);

    // Start a session, then stream the rest of the first word. data_64 is swapped to the
    // next word mid-stream; it must not disturb the latched word.
    data_64 = 64'hbb941c2b7e1d731b;
    send("start", 1'b1, 1'b0, word_a[0]);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) data_64 = 64'hbca16b888f3cafb4;
      send($sformatf("a%0d", i), 1'b0, 1'b1, word_a[i]);
    end

    // Word exhausted: the next eight requests reload and stream the new word.
    for (int i = 0; i < 8; i++) begin
      send($sformatf("b%0d", i), 1'b0, 1'b1, word_b[i]);
    end

    // Reload a third word, send three bytes, then restart mid-word with a different input.
    data_64 = 64'h0123456789abcdef;
    send("c0", 1'b0, 1'b1, 8'h01);
    send("c1", 1'b0, 1'b1, 8'h23);
    send("c2", 1'b0, 1'b1, 8'h45);
    data_64 = 64'hfedcba9876543210;
    send("restart", 1'b1, 1'b0, 8'hfe);
    send("r1", 1'b0, 1'b1, 8'hdc);

    // Start and chunk request rising together: one strobe, top byte, index restarts.
    data_64 = 64'h5aa55aa5c33cc33c;
    send("both", 1'b1, 1'b1, 8'h5a);
    send("s1", 1'b0, 1'b1, 8'ha5);
    send("s2", 1'b0, 1'b1, 8'h5a);
    send("s3", 1'b0, 1'b1, 8'ha5);
    send("s4", 1'b0, 1'b1, 8'hc3);

    // Reset mid-word after five bytes: back to IDLE, next start resends from the top.
    do_reset("rst2");
    idle_pulse("idle2", 8'h00);
    send("restart2", 1'b1, 1'b0, 8'h5a);
    send("t1", 1'b0, 1'b1, 8'ha5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_data_in_64_to_8

// File: doc/data_in_64_to_8.md
Name: data_in_64_to_8

Overview:
- Serialiser between a 64-bit data source and a byte-wide UART transmitter.
- Latches a 64-bit word and presents it one byte at a time on data_8, pulsing tx_enable for each byte.
- The first byte of a session is triggered by manual_start. Each later byte is triggered by data_in_enable, which is the transmitter's "byte done / ready for next" pulse.
- After the eighth byte, the next data_in_enable latches a fresh data_64 and continues streaming.

Parameters:
- IN_W, 64, input word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output chunk width.
- NUM_CHUNKS, IN_W/OUT_W (derived, localparam), chunks per word.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data_64  in  IN_W  word to serialise; sampled only at word-load events.
- data_in_enable  in  1  next-chunk request; level signal, may be held high for several cycles; acted on at its rising edge only.
- manual_start  in  1  session start/restart request; level signal, acted on at its rising edge only.
- data_8  out  OUT_W  current chunk; registered, held stable between updates.
- tx_enable  out  1  one-cycle strobe: data_8 has just been updated and is to be transmitted.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all of the following to 0:
  - data_8 and tx_enable;
  - chunk index idx and the running flag;
  - the latched word and both edge-detector history flops.
- Edge detection:
  - start_rise = manual_start & ~manual_start_d.
  - next_rise = data_in_enable & ~data_in_enable_d.
  - History flops reset to 0, so an input already high when reset releases counts as a rise.
- Two states:
  - IDLE (running=0): next_rise is ignored.
  - RUN (running=1).
- start_rise, from any state:
  - word <= data_64, idx <= 1, data_8 <= data_64[IN_W-1 -: OUT_W], tx_enable <= 1, running <= 1.
- next_rise in RUN with idx < NUM_CHUNKS:
  - data_8 <= word chunk idx, counted MSB-first; tx_enable <= 1; idx <= idx+1.
- next_rise in RUN with idx == NUM_CHUNKS (word exhausted):
  - word <= data_64 (new word), data_8 <= its top chunk, tx_enable <= 1, idx <= 1. Streaming continues without another manual_start.
- Simultaneous start_rise and next_rise: start_rise wins and the request is consumed once.
- Latency: outputs update at the clk edge where the input is first sampled high; they are visible in the following cycle.
- tx_enable is high for exactly one cycle per event, whatever the input pulse width.
- data_8 holds its last value indefinitely between events.
- Chunk order: MSB-first, i.e. chunk k = word[IN_W-1-k*OUT_W -: OUT_W].
- data_64 changes outside load events have no effect.
- Reset mid-word: returns to IDLE; the partial word is discarded; the next start resends from chunk 0.

Optional Feature:
- Macro: DATA_IN_LSB_FIRST_EN.
- Defined: chunk order is LSB-first, chunk k = word[k*OUT_W +: OUT_W]. The first chunk of each word is data_64[OUT_W-1:0].
- Undefined (default): MSB-first as specified above.
- All timing is identical in both builds.

Decomposition:
- Package data_in_pkg holds IN_W/OUT_W defaults, NUM_CHUNKS, the index width ($clog2(NUM_CHUNKS)+1), and the state enum {IDLE, RUN}.
- One sub-module: rise_edge_detect.
  - Ports: clk, rst_n, level in, pulse out.
  - Instantiated twice, for manual_start and data_in_enable.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> data_8=0x00, tx_enable=0; data_in_enable pulses while IDLE -> no tx_enable.
- Start: data_64=0xbb941c2b7e1d731b, manual_start high for 2 cycles -> a single one-cycle tx_enable, data_8=0xbb.
- Streaming: seven 2-cycle data_in_enable pulses, spaced ~86.8 us apart -> data_8 = 94,1c,2b,7e,1d,73,1b, exactly one tx_enable per pulse, data_8 stable between pulses.
- Word reload: set data_64=0xbca16b888f3cafb4, then eight data_in_enable pulses -> bc,a1,6b,88,8f,3c,af,b4.
- Restart and precedence:
  - manual_start mid-word (after 3 bytes) -> restarts at the top byte of the current data_64.
  - manual_start and data_in_enable rising together -> one tx_enable with the top byte.
- Reset mid-word (after 5 bytes) -> outputs 0, IDLE; the next manual_start resends from the top byte.
